// File: rtl/bullet_pool_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bullet_pool_if : raster/keyboard/collision bundle for the bullet pool       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
interface bullet_pool_if #(
   parameter int NUM_BULLETS = 4
) ();
   logic                   frame_tick;
   logic [7:0]             keycode;
   logic [9:0]             player_X;
   logic [NUM_BULLETS-1:0] hit;
   logic [9:0]             DrawX;
   logic [9:0]             DrawY;
   logic                   bullet_on;
   logic [2:0]             bullet_slot;
   logic [NUM_BULLETS-1:0] active_mask;
   logic                   fire_ack;

   modport master (
      output frame_tick, keycode, player_X, hit, DrawX, DrawY,
      input  bullet_on, bullet_slot, active_mask, fire_ack
   );

   modport slave (
      input  frame_tick, keycode, player_X, hit, DrawX, DrawY,
      output bullet_on, bullet_slot, active_mask, fire_ack
   );
endinterface
`default_nettype wire

// File: rtl/bullet_pool.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bullet_pool : multi-slot player projectile manager with fire cooldown,      |
// |               key re-arm, per-slot hit clear and 1-cycle pixel query       |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module bullet_pool #(
   parameter int         NUM_BULLETS = 4,
   parameter logic [9:0] SPAWN_Y     = 10'd420,
   parameter logic [9:0] SPEED       = 10'd4,
   parameter logic [9:0] BULLET_W    = 10'd2,
   parameter logic [9:0] BULLET_H    = 10'd8,
   parameter logic [5:0] COOLDOWN    = 6'd12,
   parameter logic [7:0] FIRE_KEY    = 8'h2C
) (
   input  wire logic     Clk,
   input  wire logic     Reset,
   bullet_pool_if.slave  bus
);

   logic [NUM_BULLETS-1:0] active_q, active_d;
   logic [9:0]             x_q [NUM_BULLETS];
   logic [9:0]             x_d [NUM_BULLETS];
   logic [9:0]             y_q [NUM_BULLETS];
   logic [9:0]             y_d [NUM_BULLETS];
   logic [5:0]             cool_q, cool_d;
   logic                   armed_q, armed_d;
   logic                   fire_ack_q, fire_ack_d;
   logic                   on_q, on_d;
   logic [2:0]             slot_q, slot_d;

   logic [2:0]             free_idx;
   logic                   any_free;
   logic                   fire;

   always_comb begin
      free_idx = 3'd0;
      any_free = 1'b0;
      for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
         if (!active_q[i]) begin
            free_idx = 3'(i);
            any_free = 1'b1;
         end
      end

      fire = bus.frame_tick && (bus.keycode == FIRE_KEY) && armed_q &&
             (cool_q == 6'd0) && any_free;

      active_d = active_q;
      x_d      = x_q;
      y_d      = y_q;
      // Free-slot choice uses pre-update state, so a slot cleared this cycle cannot respawn yet
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (active_q[i]) begin
            if (bus.hit[i]) begin
               active_d[i] = 1'b0;
            end else if (bus.frame_tick) begin
               if (y_q[i] < SPEED) begin
                  active_d[i] = 1'b0;
               end else begin
                  y_d[i] = y_q[i] - SPEED;
               end
            end
         end else if (fire && (free_idx == 3'(i))) begin
            active_d[i] = 1'b1;
            x_d[i]      = bus.player_X;
            y_d[i]      = SPAWN_Y;
         end
      end

      cool_d = cool_q;
      if (fire) begin
         cool_d = COOLDOWN;
      end else if (bus.frame_tick && (cool_q != 6'd0)) begin
         cool_d = cool_q - 6'd1;
      end

      armed_d = armed_q;
      if (fire) begin
         armed_d = 1'b0;
      end else if (bus.keycode != FIRE_KEY) begin
         armed_d = 1'b1;
      end

      fire_ack_d = fire;

      on_d   = 1'b0;
      slot_d = 3'd0;
      for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
         if (active_q[i] &&
             (bus.DrawX >= x_q[i]) &&
             ({1'b0, bus.DrawX} < ({1'b0, x_q[i]} + {1'b0, BULLET_W})) &&
             (bus.DrawY >= y_q[i]) &&
             ({1'b0, bus.DrawY} < ({1'b0, y_q[i]} + {1'b0, BULLET_H}))) begin
            on_d   = 1'b1;
            slot_d = 3'(i);
         end
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         active_q   <= '0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            x_q[i] <= 10'd0;
            y_q[i] <= 10'd0;
         end
         cool_q     <= 6'd0;
         armed_q    <= 1'b1;
         fire_ack_q <= 1'b0;
         on_q       <= 1'b0;
         slot_q     <= 3'd0;
      end else begin
         active_q   <= active_d;
         x_q        <= x_d;
         y_q        <= y_d;
         cool_q     <= cool_d;
         armed_q    <= armed_d;
         fire_ack_q <= fire_ack_d;
         on_q       <= on_d;
         slot_q     <= slot_d;
      end
   end

   assign bus.active_mask = active_q;
   assign bus.fire_ack    = fire_ack_q;
   assign bus.bullet_on   = on_q;
   assign bus.bullet_slot = slot_q;

endmodule
`default_nettype wire
